// File: rtl/cdb_multilane_pkg.sv
// Shared types and configuration for the multi-lane common data bus.
package cdb_multilane_pkg;

  localparam int unsigned CDB_N_LANES = 2;

  typedef struct packed {
    logic [3:0]  rob_idx;
    logic [31:0] value;
  } cdb_data_t;

endpackage

// File: rtl/cdb_multilane_rr_picker.sv
// Round-robin picker over channels 1..N_CH-1, starting at start_i and skipping masked requests.
module cdb_rr_picker #(
  parameter int unsigned N_CH = 4,
  localparam int unsigned PW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [N_CH-1:0] mask_i,
  input  logic [PW-1:0]   start_i,
  output logic [N_CH-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            found_o
);

  int ch;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    ch      = 0;
    for (int o = 0; o < int'(N_CH) - 1; o++) begin
      ch = int'(start_i) + o;
      // Channel 0 is never part of the ring, so wrap N_CH-1 -> 1.
      if (ch >= int'(N_CH)) ch = ch - (int'(N_CH) - 1);
      if (!found_o && req_i[ch] && !mask_i[ch]) begin
        found_o     = 1'b1;
        idx_o       = PW'(ch);
        grant_o[ch] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_multilane.sv
// Multi-lane common data bus: channel 0 has fixed priority, channels 1..N_CH-1 share the
// remaining lanes round-robin; lane outputs are registered.
module cdb_multilane
  import cdb_multilane_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned N_LANES = CDB_N_LANES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [N_CH-1:0]   valid_i,
  output logic [N_CH-1:0]   ready_o,
  input  cdb_data_t         data_i [N_CH],
  input  logic              rob_ready_i,
  output logic [N_LANES-1:0] valid_o,
  output cdb_data_t         data_o [N_LANES]
);

  localparam int unsigned PW = $clog2(N_CH);

  logic [N_LANES-1:0] lane_valid_q;
  cdb_data_t          lane_data_q [N_LANES];
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0] pick_grant [N_LANES];
  logic [PW-1:0]   pick_idx   [N_LANES];
  logic            pick_found [N_LANES];

  // Each picker masks channel 0 plus everything granted by the pickers before it.
  for (genvar l = 0; l < int'(N_LANES); l++) begin : g_pick
    logic [N_CH-1:0] mask;
    logic [N_CH-1:0] grant;
    logic [PW-1:0]   idx;
    logic            found;

    if (l == 0) begin : g_first
      assign mask = N_CH'(1);
    end else begin : g_next
      assign mask = g_pick[l-1].mask | g_pick[l-1].grant;
    end

    cdb_rr_picker #(
      .N_CH (N_CH)
    ) u_picker (
      .req_i   (valid_i),
      .mask_i  (mask),
      .start_i (rr_ptr_q),
      .grant_o (grant),
      .idx_o   (idx),
      .found_o (found)
    );

    assign pick_grant[l] = grant;
    assign pick_idx[l]   = idx;
    assign pick_found[l] = found;
  end

  logic               load, grant_en, ch0_win, last_found;
  logic [N_LANES-1:0] lane_hit;
  logic [PW-1:0]      lane_src [N_LANES];
  logic [PW-1:0]      last_idx;
  int                 p;

  always_comb begin
    load       = !(|lane_valid_q) || rob_ready_i;
    grant_en   = load && !flush_i;
    ch0_win    = grant_en && valid_i[0];
    ready_o    = '0;
    lane_hit   = '0;
    last_found = 1'b0;
    last_idx   = '0;
    p          = 0;
    for (int l = 0; l < int'(N_LANES); l++) lane_src[l] = '0;
    ready_o[0] = ch0_win;
    for (int l = 0; l < int'(N_LANES); l++) begin
      if (ch0_win && l == 0) begin
        lane_hit[0] = 1'b1;
      end else begin
        // With channel 0 on lane 0, picker k feeds lane k+1.
        p = ch0_win ? l - 1 : l;
        if (grant_en && pick_found[p]) begin
          lane_hit[l] = 1'b1;
          lane_src[l] = pick_idx[p];
          ready_o     = ready_o | pick_grant[p];
          last_found  = 1'b1;
          last_idx    = pick_idx[p];
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (last_found) rr_ptr_d = (last_idx == PW'(N_CH - 1)) ? PW'(1) : last_idx + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_valid_q <= '0;
      rr_ptr_q     <= PW'(1);
      for (int l = 0; l < int'(N_LANES); l++) lane_data_q[l] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (flush_i) begin
        lane_valid_q <= '0;
      end else if (load) begin
        lane_valid_q <= lane_hit;
        for (int l = 0; l < int'(N_LANES); l++) begin
          if (lane_hit[l]) lane_data_q[l] <= data_i[lane_src[l]];
        end
      end
    end
  end

  assign valid_o = lane_valid_q;
  assign data_o  = lane_data_q;

endmodule

// File: tb/tb_cdb_multilane.sv
// Bench for cdb_multilane (4 channels, 2 lanes): directed scenarios plus random traffic
// against a list-based reference model.
module tb_cdb_multilane;
  import cdb_multilane_pkg::*;

  localparam int NCH = 4;
  localparam int NL  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            rob = 1'b0;
  logic [NCH-1:0]  valid = '0;
  logic [NCH-1:0]  ready;
  cdb_data_t       din [NCH];
  logic [NL-1:0]   vout;
  cdb_data_t       dout [NL];
  cdb_data_t       held [NL];

  int vec = 0;
  int errs = 0;

  // Reference model state
  logic [NL-1:0]   m_lv;
  cdb_data_t       m_ld [NL];
  int              m_ptr, m_ptr_next, m_gn;
  int              m_gch [NL];
  logic            m_load;
  logic [NCH-1:0]  m_rdy;

  cdb_multilane #(
    .N_CH    (NCH),
    .N_LANES (NL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .valid_i     (valid),
    .ready_o     (ready),
    .data_i      (din),
    .rob_ready_i (rob),
    .valid_o     (vout),
    .data_o      (dout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lv  = '0;
    m_ptr = 1;
    for (int k = 0; k < NL; k++) m_ld[k] = '0;
  endtask

  // Grants as an ordered list: channel 0 first, then the ring 1..NCH-1 from the pointer.
  task automatic model_predict();
    int last, ch;
    m_gn   = 0;
    m_rdy  = '0;
    last   = 0;
    m_load = !flush && ((m_lv == '0) || rob);
    if (m_load) begin
      if (valid[0]) begin
        m_gch[m_gn] = 0;
        m_gn++;
      end
      for (int o = 0; o < NCH - 1; o++) begin
        ch = 1 + ((m_ptr - 1 + o) % (NCH - 1));
        if (valid[ch] && m_gn < NL) begin
          m_gch[m_gn] = ch;
          m_gn++;
          last = ch;
        end
      end
    end
    for (int k = 0; k < m_gn; k++) m_rdy[m_gch[k]] = 1'b1;
    m_ptr_next = (last != 0) ? 1 + (last % (NCH - 1)) : m_ptr;
  endtask

  task automatic model_commit();
    if (flush) begin
      m_lv = '0;
    end else if (m_load) begin
      for (int k = 0; k < NL; k++) begin
        m_lv[k] = (k < m_gn);
        if (k < m_gn) m_ld[k] = din[m_gch[k]];
      end
    end
    m_ptr = m_ptr_next;
  endtask

  task automatic set_inputs(input logic [NCH-1:0] v, input logic rr, input logic fl);
    @(negedge clk);
    valid = v;
    rob   = rr;
    flush = fl;
    for (int i = 0; i < NCH; i++) begin
      din[i].rob_idx = 4'($urandom);
      din[i].value   = $urandom;
    end
    #1;
    model_predict();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    valid = '0;
    rob   = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if (vout !== 2'b00 || dout[0] !== '0 || dout[1] !== '0) begin
      errs++;
      $display("FAIL reset_outputs: valid_o=%b data_o=%h/%h, expected 00 and zero data",
               vout, dout[0], dout[1]);
    end
    vec++;
    if (dut.rr_ptr_q !== 2'd1 || ready !== 4'b0000) begin
      errs++;
      $display("FAIL reset_ptr_ready: rr_ptr=%0d ready_o=%b, expected 1 and 0000",
               dut.rr_ptr_q, ready);
    end
    set_inputs(4'b1111, 1'b1, 1'b0);
    vec++;
    if (ready !== 4'b0011) begin
      errs++;
      $display("FAIL reset_empty_load: ready_o=%b, expected 0011", ready);
    end
    clock_edge();
    vec++;
    if (vout !== 2'b11) begin
      errs++;
      $display("FAIL reset_fill: valid_o=%b, expected 11", vout);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (vout !== 2'b00 || dout[0] !== '0 || dout[1] !== '0) begin
      errs++;
      $display("FAIL reset_async: valid_o=%b data_o=%h/%h, expected 00 and zero data",
               vout, dout[0], dout[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    vec++;
    if (dut.rr_ptr_q !== 2'd1) begin
      errs++;
      $display("FAIL reset_ptr_after: rr_ptr=%0d, expected 1", dut.rr_ptr_q);
    end
  endtask

  task automatic test_priority();
    logic [NCH-1:0] exp_rdy [2];
    int             exp_l1 [2];
    exp_rdy = '{4'b0011, 4'b0101};
    exp_l1  = '{1, 2};
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_inputs(4'b1111, 1'b1, 1'b0);
      vec++;
      if (ready !== exp_rdy[c]) begin
        errs++;
        $display("FAIL priority_ready[%0d]: ready_o=%b, expected %b", c, ready, exp_rdy[c]);
      end
      clock_edge();
      vec++;
      if (vout !== 2'b11 || dout[0] !== din[0] || dout[1] !== din[exp_l1[c]]) begin
        errs++;
        $display("FAIL priority_lanes[%0d]: valid_o=%b data_o=%h/%h, expected 11 %h/%h",
                 c, vout, dout[0], dout[1], din[0], din[exp_l1[c]]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [NCH-1:0] exp_rdy [3];
    int             exp_l0 [3];
    int             exp_l1 [3];
    int             exp_ptr [3];
    exp_rdy = '{4'b0110, 4'b1010, 4'b1100};
    exp_l0  = '{1, 3, 2};
    exp_l1  = '{2, 1, 3};
    exp_ptr = '{3, 2, 1};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_inputs(4'b1110, 1'b1, 1'b0);
      vec++;
      if (ready !== exp_rdy[c]) begin
        errs++;
        $display("FAIL rr_ready[%0d]: ready_o=%b, expected %b", c, ready, exp_rdy[c]);
      end
      clock_edge();
      vec++;
      if (vout !== 2'b11 || dout[0] !== din[exp_l0[c]] || dout[1] !== din[exp_l1[c]] ||
          dut.rr_ptr_q !== 2'(exp_ptr[c])) begin
        errs++;
        $display("FAIL rr_lanes[%0d]: valid_o=%b data_o=%h/%h rr_ptr=%0d, expected 11 %h/%h %0d",
                 c, vout, dout[0], dout[1], dut.rr_ptr_q, din[exp_l0[c]], din[exp_l1[c]],
                 exp_ptr[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_inputs(4'b1111, 1'b1, 1'b0);
    clock_edge();
    held = dout;
    for (int c = 0; c < 3; c++) begin
      set_inputs(4'b1111, 1'b0, 1'b0);
      vec++;
      if (ready !== 4'b0000) begin
        errs++;
        $display("FAIL bp_ready[%0d]: ready_o=%b, expected 0000", c, ready);
      end
      clock_edge();
      vec++;
      if (vout !== 2'b11 || dout[0] !== held[0] || dout[1] !== held[1]) begin
        errs++;
        $display("FAIL bp_hold[%0d]: valid_o=%b data_o=%h/%h, expected 11 %h/%h",
                 c, vout, dout[0], dout[1], held[0], held[1]);
      end
    end
    set_inputs(4'b1111, 1'b1, 1'b0);
    vec++;
    if (ready !== 4'b0101) begin
      errs++;
      $display("FAIL bp_release_ready: ready_o=%b, expected 0101", ready);
    end
    clock_edge();
    vec++;
    if (vout !== 2'b11 || dout[0] !== din[0] || dout[1] !== din[2]) begin
      errs++;
      $display("FAIL bp_release_lanes: valid_o=%b data_o=%h/%h, expected 11 %h/%h",
               vout, dout[0], dout[1], din[0], din[2]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_inputs(4'b1111, 1'b1, 1'b0);
    clock_edge();
    set_inputs(4'b1111, 1'b1, 1'b1);
    vec++;
    if (ready !== 4'b0000) begin
      errs++;
      $display("FAIL flush_ready: ready_o=%b, expected 0000", ready);
    end
    clock_edge();
    vec++;
    if (vout !== 2'b00 || dut.rr_ptr_q !== 2'd2) begin
      errs++;
      $display("FAIL flush_clear: valid_o=%b rr_ptr=%0d, expected 00 and 2",
               vout, dut.rr_ptr_q);
    end
  endtask

  task automatic test_partial();
    do_reset();
    set_inputs(4'b1000, 1'b1, 1'b0);
    vec++;
    if (ready !== 4'b1000) begin
      errs++;
      $display("FAIL partial_ready: ready_o=%b, expected 1000", ready);
    end
    clock_edge();
    vec++;
    if (vout !== 2'b01 || dout[0] !== din[3] || dut.rr_ptr_q !== 2'd1) begin
      errs++;
      $display("FAIL partial_lanes: valid_o=%b data_o[0]=%h rr_ptr=%0d, expected 01 %h 1",
               vout, dout[0], dut.rr_ptr_q, din[3]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_inputs(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      vec++;
      if (ready !== m_rdy) begin
        errs++;
        $display("FAIL rand_ready[%0d]: ready_o=%b, expected %b", c, ready, m_rdy);
      end
      clock_edge();
      vec++;
      if (vout !== m_lv || dut.rr_ptr_q !== 2'(m_ptr)) begin
        errs++;
        $display("FAIL rand_state[%0d]: valid_o=%b rr_ptr=%0d, expected %b %0d",
                 c, vout, dut.rr_ptr_q, m_lv, m_ptr);
      end
      for (int k = 0; k < NL; k++) begin
        if (m_lv[k]) begin
          vec++;
          if (dout[k] !== m_ld[k]) begin
            errs++;
            $display("FAIL rand_data[%0d] lane %0d: data_o=%h, expected %h",
                     c, k, dout[k], m_ld[k]);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) din[i] = '0;
    model_reset();
    test_reset();
    test_priority();
    test_rr_wrap();
    test_backpressure();
    test_flush();
    test_partial();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/cdb_multilane.md
# cdb_multilane

Parametrised common data bus for the execution pipeline: arbitrates among `N_CH` result producers and broadcasts up to `N_LANES` results per cycle to the ROB, reservation stations and register-status logic. Channel 0 is the fixed maximum-priority producer. Channels 1..N_CH-1 share the remaining lanes under round-robin arbitration. Outputs are registered, which breaks the producer-to-ROB combinational path of the single-lane bus.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels, including max-priority channel 0; legal values ≥ 2.
- `N_LANES`, default 2: number of broadcast lanes; legal range 1..N_CH.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `flush_i`, in, 1: pipeline flush, synchronous.
- `valid_i`, in, N_CH: per-channel result valid.
- `ready_o`, out, N_CH: per-channel grant; the handshake completes when `valid_i[i] && ready_o[i]`.
- `data_i`, in, N_CH × `cdb_data_t`: per-channel result.
- `rob_ready_i`, in, 1: the ROB consumes the whole registered lane bundle this cycle.
- `valid_o`, out, N_LANES: lane valid; always thermometer-coded from lane 0.
- `data_o`, out, N_LANES × `cdb_data_t`: lane data.

## Operation
- **State.** The block holds:
  - `lane_valid_q[N_LANES]`
  - `lane_data_q[N_LANES]`
  - `rr_ptr_q`, of width clog2(N_CH), range 1..N_CH-1.
- **Load enable.** `load = !(|lane_valid_q) || rob_ready_i`, evaluated when `flush_i` is low.
- **Grant selection when `load`=1:**
  - Channel 0 is granted first if `valid_i[0]`.
  - The remaining lanes are granted to valid channels 1..N_CH-1 in round-robin order starting at `rr_ptr_q` and wrapping from N_CH-1 to 1.
  - Up to `N_LANES` total grants are issued.
- **Lane assignment.**
  - The k-th grant, in priority order, is written to lane k.
  - Lanes with no grant load `valid`=0; their data is don't-care but must be held stable.
- **ready_o.**
  - `ready_o[i]` = 1 exactly when channel i is granted.
  - It depends combinationally on `valid_i` and on the registered state; it has no dependence on `data_i`.
  - `ready_o` is 0 for every channel when `load`=0 or `flush_i`=1.
- **Round-robin pointer.**
  - If at least one low-priority channel is granted, `rr_ptr_q` moves to one past the last granted low-priority channel, wrapping N_CH-1 → 1.
  - Otherwise `rr_ptr_q` is unchanged.
  - A grant to channel 0 never moves the pointer.
- **Hold.** When `load`=0, the lane registers hold and `valid_o`/`data_o` stay stable until `rob_ready_i`.
- **Flush.**
  - All `lane_valid_q` clear on the next edge.
  - No grants are issued in the flush cycle.
  - `rr_ptr_q` holds.
  - Flush takes precedence over `rob_ready_i` and over load.
- **Reset.**
  - `lane_valid_q` = 0, `lane_data_q` = 0, `rr_ptr_q` = 1.
  - Consequently, after reset `valid_o` = 0, `data_o` = 0, and `ready_o` = 0 unless inputs are valid (the registers are empty, so `load`=1).
  - Assertion of reset mid-operation discards all lane contents immediately.
- **Starvation.** The bus is starvation-free for channels 1..N_CH-1 only if channel 0 does not hold `valid_i[0]` continuously while `N_LANES`=1. This is documented, not checked.

## Timing
- Latency: a handshake in cycle t produces `valid_o` in cycle t+1.
- Throughput: up to `N_LANES` results per cycle with `rob_ready_i` held high.
- Consume and refill in the same cycle: when `rob_ready_i`=1 and new grants occur, the new bundle appears at t+1 with no bubble.
- Empty bus: `load`=1 regardless of `rob_ready_i`.
- Worst-case combinational path: `valid_i` → picker chain → `ready_o`. The chain depth is `N_LANES` sequential pickers.

## Structure
- `cdb_data_t` stays in `expipe_pkg`.
- Add `CDB_N_LANES` (default 2) to `len5_config_pkg`; `N_CH` is derived from `MAX_EU_N` at the instantiation site.
- Sub-module `cdb_rr_picker`:
  - Inputs: request vector, mask, start pointer.
  - Outputs: one-hot grant, granted index, found flag.
  - Instantiated `N_LANES` times, each masking out the earlier grants.
- Channel-0 priority and the lane registers live in the top module.

## Test plan
- **Reset:** assert `rst_i` mid-stream while `valid_o`=2'b11 → asynchronously `valid_o`=0, `data_o`=0, and `rr_ptr`=1 after release.
- **Priority:** `N_CH`=4, `N_LANES`=2, `valid_i`=4'b1111, ROB ready.
  - Cycle 1: `ready_o`=4'b0011, lanes get ch0 and ch1.
  - Cycle 2: `ready_o`=4'b0101, lanes get ch0 and ch2; `valid_o`=2'b11 each cycle.
- **Round-robin wrap:** `valid_i`=4'b1110, ROB ready, `N_LANES`=2 → grant sequence {1,2}, {3,1}, {2,3}. `rr_ptr` follows 1 → 3 → 2 → 1.
- **Backpressure:**
  - Fill lanes, then hold `rob_ready_i`=0 for 3 cycles → `ready_o`=0 and `data_o` stable.
  - Raise `rob_ready_i` → bundle consumed and next grants are issued in the same cycle.
- **Flush:**
  - `flush_i`=1 while lanes are valid and `valid_i`=4'b1111 → `ready_o`=0 that cycle, `valid_o`=0 the next cycle, `rr_ptr` unchanged.
- **Partial bundle:** only `valid_i[3]` high → `valid_o`=2'b01, lane 0 carries ch3 data, `rr_ptr`=1.
